// File: rtl/matrix_decoder_top.sv
// rtl/matrix_decoder_top.sv - inverse matrix decoder: loads 64 encoded lines, undoes pi and rho, streams decoded lines
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        level request to begin a decode (ignored in LOAD and WRITE)
//   donee        decode complete; held while start stays high
//   cnt_value    current line index, shared by the line fetch and the write-back
//   line_in      encoded line cnt_value, driven combinationally by the source
//   write_enable write_value valid this cycle
//   write_value  decoded line cnt_value
//   data_out     (only with MATRIX_DECODER_FLAT_OUT_EN) all 64 decoded lines, flat
//
// Optional feature macro: MATRIX_DECODER_FLAT_OUT_EN
module matrix_decoder_top #(
    parameter int LINES = 64,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             donee,
    output logic [5:0]       cnt_value,
    input  logic [WIDTH-1:0] line_in,
    output logic             write_enable,
    output logic [WIDTH-1:0] write_value
`ifdef MATRIX_DECODER_FLAT_OUT_EN
    ,
    output logic [LINES*WIDTH-1:0] data_out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    // Rho offsets indexed by 5*x+y.
    localparam logic [5:0] RHO [25] = '{
        6'd0,  6'd36, 6'd3,  6'd41, 6'd18,
        6'd1,  6'd44, 6'd10, 6'd45, 6'd2,
        6'd62, 6'd6,  6'd43, 6'd15, 6'd61,
        6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
        6'd27, 6'd20, 6'd39, 6'd8,  6'd14
    };

    state_t           state;
    logic [WIDTH-1:0] line_buf [LINES];
    logic [5:0]       dec_z;
    logic [WIDTH-1:0] dec_line;

    // Decoded line for the index that will be presented after the next edge.
    // On the last LOAD edge this is line 0; line 63 is still being stored then,
    // but no rho offset equals 63, so D(0) never reads it.
    always_comb begin
        dec_z    = (state == WRITE) ? cnt_value + 6'd1 : 6'd0;
        dec_line = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                // 6-bit add wraps, giving (z + r) mod 64.
                dec_line[5*y+x] = line_buf[6'(dec_z + RHO[5*x+y])][5*((2*x+3*y)%5)+y];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt_value    <= '0;
            donee        <= 1'b0;
            write_enable <= 1'b0;
            write_value  <= '0;
            for (int i = 0; i < LINES; i++) begin
                line_buf[i] <= '0;
            end
`ifdef MATRIX_DECODER_FLAT_OUT_EN
            data_out     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        cnt_value <= '0;
`ifdef MATRIX_DECODER_FLAT_OUT_EN
                        data_out  <= '0;
`endif
                    end
                end
                LOAD: begin
                    line_buf[cnt_value] <= line_in;
                    cnt_value           <= cnt_value + 6'd1;
                    if (cnt_value == 6'd63) begin
                        state        <= WRITE;
                        write_enable <= 1'b1;
                        write_value  <= dec_line;
`ifdef MATRIX_DECODER_FLAT_OUT_EN
                        data_out[0 +: WIDTH] <= dec_line;
`endif
                    end
                end
                WRITE: begin
                    cnt_value <= cnt_value + 6'd1;
                    if (cnt_value == 6'd63) begin
                        state        <= DONE;
                        write_enable <= 1'b0;
                        donee        <= 1'b1;
                    end else begin
                        write_value <= dec_line;
`ifdef MATRIX_DECODER_FLAT_OUT_EN
                        data_out[WIDTH*int'(dec_z) +: WIDTH] <= dec_line;
`endif
                    end
                end
                DONE: begin
                    // A held start parks here so it cannot re-trigger a decode.
                    if (!start) begin
                        state <= IDLE;
                        donee <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_decoder_top.sv
// tb/tb_matrix_decoder_top.sv - self-checking bench for matrix_decoder_top
module tb_matrix_decoder_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        donee;
    logic [5:0]  cnt_value;
    logic [24:0] line_in;
    logic        write_enable;
    logic [24:0] write_value;
`ifdef MATRIX_DECODER_FLAT_OUT_EN
    logic [1599:0] data_out;
    logic [1599:0] flat;
`endif

    always #5 clk = ~clk;

    matrix_decoder_top dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .donee       (donee),
        .cnt_value   (cnt_value),
        .line_in     (line_in),
        .write_enable(write_enable),
        .write_value (write_value)
`ifdef MATRIX_DECODER_FLAT_OUT_EN
        ,
        .data_out    (data_out)
`endif
    );

    int rho [5][5] = '{
        '{0, 36, 3, 41, 18},
        '{1, 44, 10, 45, 2},
        '{62, 6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39, 8, 14}
    };

    logic [24:0] src  [64];
    logic [24:0] orig [64];
    logic [24:0] expd [64];
    logic [24:0] got  [64];

    int n_checks = 0;
    int n_fails  = 0;
    int strobes;
    int first_we;
    int first_done;
    int late_strobes;
    logic order_bad;

    assign line_in = src[cnt_value];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Forward transform: lane (x,y) of decoded line z lands at encoded line
    // (z + r[x][y]) mod 64, bit position of lane (y, (2x+3y) mod 5).
    task automatic encode_model();
        for (int z = 0; z < 64; z++) src[z] = '0;
        for (int z = 0; z < 64; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    src[(z + rho[x][y]) % 64][5 * ((2 * x + 3 * y) % 5) + y] = orig[z][5 * y + x];
    endtask

    task automatic decode_model();
        for (int z = 0; z < 64; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    expd[z][5 * y + x] = src[(z + rho[x][y]) % 64][5 * ((2 * x + 3 * y) % 5) + y];
    endtask

    task automatic clear_src();
        for (int z = 0; z < 64; z++) begin
            src[z]  = '0;
            expd[z] = '0;
        end
    endtask

    // k counts rising edges after the one that samples start.
    task automatic run(input bit hold);
        strobes = 0; first_we = -1; first_done = -1; order_bad = 1'b0;
        for (int z = 0; z < 64; z++) got[z] = '0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) if (!hold) start = 1'b0;
        for (int k = 1; k <= 135; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (write_enable) begin
                if (cnt_value != strobes[5:0]) order_bad = 1'b1;
                got[cnt_value] = write_value;
                if (first_we < 0) first_we = k;
                strobes++;
            end
            if (donee && first_done < 0) begin
                first_done = k;
`ifdef MATRIX_DECODER_FLAT_OUT_EN
                flat = data_out;
`endif
            end
        end
        chk("first_write_edge", first_we, 64);
        chk("donee_edge", first_done, 128);
        chk("strobe_count", strobes, 64);
        chk("cnt_order", order_bad, 0);
    endtask

    task automatic cmp_lines(input string tag);
        int bad;
        bad = 0;
        for (int z = 0; z < 64; z++) begin
            n_checks++;
            assert (got[z] === expd[z])
            else begin
                n_fails++;
                bad++;
                $error("FAIL %s line %0d: observed %0h expected %0h", tag, z, got[z], expd[z]);
            end
`ifdef MATRIX_DECODER_FLAT_OUT_EN
            chk($sformatf("%s_flat%0d", tag, z), flat[25*z +: 25], expd[z]);
`endif
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        clear_src();
        repeat (2) @(negedge clk);
        chk("rst_cnt", cnt_value, 0);
        chk("rst_donee", donee, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_wv", write_value, 0);
        @(negedge clk) rst = 1'b1;

        // All-zero state.
        clear_src();
        run(0);
        cmp_lines("zero");
        chk("idle_after_done", donee, 0);

        // Single bits, expectations worked out by hand.
        clear_src();
        src[0][0] = 1'b1;
        expd[0] = 25'h1;
        run(0);
        cmp_lines("bit_l0b0");

        clear_src();
        src[5][10] = 1'b1;
        expd[4] = 25'h2;
        run(0);
        cmp_lines("bit_l5b10");

        clear_src();
        src[0][10] = 1'b1;
        expd[63] = 25'h2;
        run(0);
        cmp_lines("wrap_l0b10");

        // Round trip: random original lines through the forward transform.
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
        encode_model();
        for (int z = 0; z < 64; z++) expd[z] = orig[z];
        run(0);
        cmp_lines("round_trip");

        // Random encoded state against the decode formula.
        for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
        decode_model();
        run(0);
        cmp_lines("random");

        // Reset during LOAD line 30.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 40 && cnt_value != 6'd30; k++) @(negedge clk);
        chk("reach_line30", cnt_value, 30);
        rst = 1'b0;
        #1;
        chk("abort_cnt", cnt_value, 0);
        chk("abort_donee", donee, 0);
        chk("abort_we", write_enable, 0);
        chk("abort_wv", write_value, 0);
        @(negedge clk) rst = 1'b1;
        late_strobes = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (write_enable || donee) late_strobes++;
        end
        chk("no_write_after_abort", late_strobes, 0);

        // Re-run after abort with fresh random data.
        for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
        decode_model();
        run(0);
        cmp_lines("rerun");

        // start held through DONE.
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
        encode_model();
        for (int z = 0; z < 64; z++) expd[z] = orig[z];
        run(1);
        cmp_lines("held");
        chk("held_donee", donee, 1);
        chk("held_cnt", cnt_value, 0);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_donee", donee, 0);
        late_strobes = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (write_enable) late_strobes++;
        end
        chk("no_retrigger", late_strobes, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
